// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: single-outstanding read front-end for a synchronous 32-bit ROM.
// Latency: miss 2 cycles accept->rsp_valid; prefetch hit 1 cycle (ROM_FETCH_PREFETCH_EN only).
// Backpressure: rsp_valid/rsp_data held until rsp_ready; req_ready low while a response stalls.
//
// Ports: CLK/RST      single clock, synchronous active-high reset
//        req_*        request channel (valid/ready, word address)
//        rsp_*        response channel (valid/ready, data, prefetch-hit flag)
//        rom_en/rom_a ROM strobe and word address, driven from registers only
//        rom_do       ROM read data, valid one cycle after rom_a
// Optional feature: define ROM_FETCH_PREFETCH_EN to add a one-entry next-sequential
// prefetch buffer; without it rsp_hit is tied low.
module rom_fetch_ctrl #(
    parameter  int MEM_WORDS = 8192,              // must be a power of two
    localparam int ADR_WIDTH = $clog2(MEM_WORDS)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADR_WIDTH-1:0] req_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 rsp_hit,
    output logic                 rom_en,
    output logic [ADR_WIDTH-1:0] rom_a,
    input  logic [31:0]          rom_do
);

`ifdef ROM_FETCH_PREFETCH_EN
    typedef enum logic [2:0] {S_IDLE, S_READ, S_RESP, S_PF_READ, S_PF_CAPT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} state_t;
`endif

    state_t                 state_q, state_d;
    logic [ADR_WIDTH-1:0]   addr_q, addr_d;

`ifdef ROM_FETCH_PREFETCH_EN
    logic                   hit_q, hit_d;
    logic                   pf_valid_q, pf_valid_d;
    logic [ADR_WIDTH-1:0]   pf_addr_q, pf_addr_d;
    logic [31:0]            pf_data_q, pf_data_d;
    logic [ADR_WIDTH-1:0]   addr_inc;

    // Natural ADR_WIDTH overflow gives the MEM_WORDS-1 -> 0 wrap.
    assign addr_inc = addr_q + ADR_WIDTH'(1);
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rom_en    = 1'b0;
        rom_a     = addr_q;
`ifdef ROM_FETCH_PREFETCH_EN
        hit_d      = hit_q;
        pf_valid_d = pf_valid_q;
        pf_addr_d  = pf_addr_q;
        pf_data_d  = pf_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d = req_addr;
`ifdef ROM_FETCH_PREFETCH_EN
                    // Buffer hit skips the ROM access entirely.
                    if (pf_valid_q && (req_addr == pf_addr_q)) begin
                        hit_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        hit_d   = 1'b0;
                        state_d = S_READ;
                    end
`else
                    state_d = S_READ;
`endif
                end
            end
            S_READ: begin
                rom_en  = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                // Keep re-reading addr_q so rom_do stays stable while stalled.
                rsp_valid = 1'b1;
                rom_en    = 1'b1;
                req_ready = rsp_ready;
                if (rsp_ready) begin
`ifdef ROM_FETCH_PREFETCH_EN
                    hit_d = 1'b0;
`endif
                    if (req_valid) begin
                        addr_d  = req_addr;
                        state_d = S_READ;
                    end else begin
`ifdef ROM_FETCH_PREFETCH_EN
                        state_d = S_PF_READ;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
            end
`ifdef ROM_FETCH_PREFETCH_EN
            S_PF_READ, S_PF_CAPT: begin
                req_ready = 1'b1;
                rom_a     = addr_inc;
                rom_en    = (state_q == S_PF_READ);
                if (req_valid) begin
                    // A real request always wins over the speculative fetch.
                    pf_valid_d = 1'b0;
                    addr_d     = req_addr;
                    state_d    = S_READ;
                end else if (state_q == S_PF_READ) begin
                    state_d = S_PF_CAPT;
                end else begin
                    pf_data_d  = rom_do;
                    pf_addr_d  = addr_inc;
                    pf_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ROM_FETCH_PREFETCH_EN
    assign rsp_data = hit_q ? pf_data_q : rom_do;
    assign rsp_hit  = hit_q;
`else
    assign rsp_data = rom_do;
    assign rsp_hit  = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
`ifdef ROM_FETCH_PREFETCH_EN
            hit_q      <= 1'b0;
            pf_valid_q <= 1'b0;
            pf_addr_q  <= '0;
            pf_data_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
`ifdef ROM_FETCH_PREFETCH_EN
            hit_q      <= hit_d;
            pf_valid_q <= pf_valid_d;
            pf_addr_q  <= pf_addr_d;
            pf_data_q  <= pf_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed and randomized checks of rom_fetch_ctrl against a ROM array model,
// an in-order request queue and a fixed latency expectation.
module tb_rom_fetch_ctrl;
    localparam int MEM_WORDS = 8192;
    localparam int AW        = $clog2(MEM_WORDS);
`ifdef ROM_FETCH_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_hit;
    logic          rom_en;
    logic [AW-1:0] rom_a;
    logic [31:0]   rom_do;

    logic [31:0]   mem [MEM_WORDS];
    int            ncmp  = 0;
    int            nfail = 0;

    rom_fetch_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_hit   (rsp_hit),
        .rom_en    (rom_en),
        .rom_a     (rom_a),
        .rom_do    (rom_do)
    );

    always #5 CLK = ~CLK;

    // Synchronous ROM: data for the address presented at an edge appears after it.
    always @(posedge CLK) if (rom_en) rom_do <= mem[rom_a];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        #1;
        while (!req_ready && w < 20) begin @(negedge CLK); #1; w++; end
        check({tag, ".accept"}, req_ready, 1);
    endtask

    // One request, a stall of 'stall' cycles once the response shows, then handshake.
    task automatic read_txn(input string tag, input logic [AW-1:0] addr, input int stall,
                            input int exp_lat, input bit exp_hit);
        int lat;
        req_valid = 1'b1; req_addr = addr; rsp_ready = 1'b0;
        wait_ready(tag);
        @(negedge CLK);
        req_valid = 1'b0;
        #1; lat = 1;
        while (!rsp_valid && lat < 10) begin @(negedge CLK); #1; lat++; end
        check({tag, ".lat"},  lat,      exp_lat);
        check({tag, ".data"}, rsp_data, mem[addr]);
        check({tag, ".hit"},  rsp_hit,  exp_hit);
        for (int i = 0; i < stall; i++) begin
            @(negedge CLK); #1;
            check({tag, ".hold_vld"}, rsp_valid, 1);
            check({tag, ".hold_dat"}, rsp_data,  mem[addr]);
            check({tag, ".hold_rdy"}, req_ready, 0);
            check({tag, ".hold_roma"}, rom_a,    addr);
        end
        rsp_ready = 1'b1; #1;
        check({tag, ".rdy_on_hs"}, req_ready, 1);
        @(negedge CLK);
        rsp_ready = 1'b0; #1;
        check({tag, ".vld_after_hs"}, rsp_valid, 0);
    endtask

    // Reset while a request is in flight ('cyc' = 0 -> in READ, 1 -> in RESP).
    task automatic reset_mid(input string tag, input logic [AW-1:0] addr, input int cyc);
        req_valid = 1'b1; req_addr = addr; rsp_ready = 1'b0;
        wait_ready(tag);
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (cyc) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK); #1;
        check({tag, ".vld"},   rsp_valid, 0);
        check({tag, ".en"},    rom_en,    0);
        check({tag, ".rdy"},   req_ready, 1);
        check({tag, ".roma"},  rom_a,     0);
        check({tag, ".hit"},   rsp_hit,   0);
        RST = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); #1;
            check({tag, ".stale"}, rsp_valid, 0);
        end
        rsp_ready = 1'b0;
    endtask

    // Stream of n requests; in-order scoreboard, latency, hold and single-outstanding checks.
    task automatic stream(input string tag, input int n, input bit rnd, input logic [AW-1:0] base);
        logic [AW-1:0] q_addr[$];
        int            q_cyc[$];
        int            got = 0, k = 0, c = 0, lat, last_hs = -1;
        bit            fresh = 1'b1, prev_stall = 1'b0, acc;
        logic [31:0]   prev_data = '0;
        req_valid = 1'b1; req_addr = base;
        rsp_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        while (got < n && c < 40 * n) begin
            #1;
            if (prev_stall) begin
                check({tag, ".hold_vld"}, rsp_valid, 1);
                check({tag, ".hold_dat"}, rsp_data,  prev_data);
            end
            if (rsp_valid) begin
                if (q_addr.size() == 0) begin
                    check({tag, ".spurious"}, rsp_valid, 0);
                end else begin
                    if (fresh) begin
                        lat = c - q_cyc[0];
                        if (PF) begin
                            check({tag, ".lat"}, (lat == 1 || lat == 2), 1);
                            check({tag, ".hit"}, rsp_hit, (lat == 1));
                        end else begin
                            check({tag, ".lat"}, lat, 2);
                            check({tag, ".hit"}, rsp_hit, 0);
                        end
                        fresh = 1'b0;
                    end
                    if (rsp_ready) begin
                        check({tag, ".data"}, rsp_data, mem[q_addr.pop_front()]);
                        void'(q_cyc.pop_front());
                        if (!rnd && last_hs >= 0) check({tag, ".gap"}, c - last_hs, 2);
                        last_hs = c;
                        got++;
                        fresh = 1'b1;
                    end
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            acc = req_valid && req_ready;
            if (acc) begin
                check({tag, ".outstanding"}, q_addr.size(), 0);
                q_addr.push_back(req_addr);
                q_cyc.push_back(c);
                k++;
            end
            @(negedge CLK);
            c++;
            if (acc || !req_valid) begin
                if (k < n) begin
                    req_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    req_addr  = rnd ? AW'($urandom) : AW'(base + AW'(k));
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (rnd) rsp_ready = ($urandom_range(0, 2) != 0);
        end
        check({tag, ".count"}, got, n);
        req_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        mem[16'h10] = 32'hDEADBEEF;
        mem[16'h20] = 32'h12345678;

        RST = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst.vld",  rsp_valid, 0);
        check("rst.rdy",  req_ready, 1);
        check("rst.en",   rom_en,    0);
        check("rst.roma", rom_a,     0);
        check("rst.hit",  rsp_hit,   0);
        @(negedge CLK);
        RST = 1'b0;

        read_txn("single", AW'(16'h10), 0, 2, 1'b0);
        read_txn("bp",     AW'(16'h20), 5, 2, 1'b0);
        stream("b2b", 4, 1'b0, '0);
        reset_mid("rst_read", AW'(16'h5), 0);
        reset_mid("rst_resp", AW'(16'h6), 1);
        stream("rand", 40, 1'b1, '0);

        // Sequential re-read after idle: hit only when the prefetch buffer exists.
        RST = 1'b1; @(negedge CLK); RST = 1'b0;
        read_txn("seq0",  AW'(16'h40), 0, 2, 1'b0);
        repeat (3) @(negedge CLK);
        read_txn("seq1",  AW'(16'h41), 0, PF ? 1 : 2, PF);
        read_txn("after", AW'(16'h50), 0, 2, 1'b0);
        repeat (3) @(negedge CLK);
        read_txn("top",   AW'(MEM_WORDS - 1), 0, 2, 1'b0);
        repeat (3) @(negedge CLK);
        read_txn("wrap",  AW'(0), 2, PF ? 1 : 2, PF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/rom_fetch_ctrl.md
ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

Interface
REQ-001 Parameter MEM_WORDS, 8192, ROM depth in 32-bit words; SHALL be a power of two.
REQ-002 Derived ADR_WIDTH = $clog2(MEM_WORDS), word-address width; SHALL not be a port-settable parameter.
REQ-003 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 req_valid  in  1  read request present.
REQ-006 req_ready  out  1  request accepted when req_valid & req_ready on a rising edge.
REQ-007 req_addr  in  ADR_WIDTH  word address of request.
REQ-008 rsp_valid  out  1  response data present.
REQ-009 rsp_ready  in  1  consumer takes response when rsp_valid & rsp_ready.
REQ-010 rsp_data  out  32  read word.
REQ-011 rsp_hit  out  1  response served from prefetch buffer; constant 0 when prefetch is compiled out.
REQ-012 rom_en  out  1  ROM enable, high on any cycle the ROM address is meaningful.
REQ-013 rom_a  out  ADR_WIDTH  ROM word address, registered-source only (no combinational path from req_addr).
REQ-014 rom_do  in  32  ROM read data, valid one cycle after rom_a is presented.

Function
REQ-015 FSM states IDLE, READ, RESP; IDLE on reset.
REQ-016 IDLE: req_ready=1; on accept, addr_q<=req_addr, go READ.
REQ-017 READ: req_ready=0, rom_en=1, rom_a=addr_q; next state RESP unconditionally.
REQ-018 RESP: rsp_valid=1, rsp_data=rom_do, rom_en=1, rom_a=addr_q held so rom_do stays stable while stalled.
REQ-019 RESP with rsp_ready=0: stay in RESP, rsp_data unchanged, req_ready=0.
REQ-020 RESP with rsp_ready=1: req_ready=1; if req_valid also 1, accept new request (addr_q<=req_addr) and go READ, else go IDLE.
REQ-021 Miss latency: accept at cycle N -> rsp_valid at N+2; sustained throughput one word per 2 cycles.
REQ-022 rsp_valid SHALL never deassert without a completed handshake except on RST.
REQ-023 At most one request outstanding; responses return in request order.

Reset
REQ-024 RST=1 on a rising edge: state<=IDLE, rsp_valid=0, req_ready=1 next cycle, rom_en=0, rom_a=0, rsp_hit=0, addr_q=0, prefetch buffer invalidated.
REQ-025 RST mid-operation (READ or RESP) SHALL drop the outstanding request with no response issued.

Configuration
REQ-026 Macro ROM_FETCH_PREFETCH_EN defined: one-entry sequential prefetch buffer (pf_addr, pf_data, pf_valid) plus states PF_READ, PF_CAPT.
REQ-027 With macro: after a RESP handshake not accompanied by a new request, go PF_READ with rom_a=addr_q+1 (wraps MEM_WORDS-1 -> 0), then PF_CAPT captures rom_do into pf_data, pf_valid<=1, go IDLE.
REQ-028 With macro: req_ready=1 in PF_READ/PF_CAPT; a request accepted there aborts the prefetch (pf_valid<=0) and proceeds as a miss.
REQ-029 With macro: accept in IDLE with pf_valid & req_addr==pf_addr -> next cycle rsp_valid=1, rsp_data=pf_data, rsp_hit=1 (latency 1), then normal RESP handshake rules; completion triggers prefetch of pf_addr+1.
REQ-030 Without macro: no prefetch states or storage, rsp_hit tied 0, behaviour exactly REQ-015..REQ-023.

Verification
REQ-031 Single read: ROM[0x10]=0xDEADBEEF, request 0x10 at cycle N, rsp_ready=1 -> rsp_valid at N+2, rsp_data=0xDEADBEEF, rsp_hit=0.
REQ-032 Backpressure: request 0x20 (ROM=0x12345678), rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_data stable 0x12345678, req_ready=0, rom_a=0x20 throughout.
REQ-033 Back-to-back: req_valid constant, addresses 0,1,2,3, rsp_ready=1 -> four responses in order, one every 2 cycles, data matches ROM.
REQ-034 Reset mid-op: assert RST in READ state -> next cycle rsp_valid=0, rom_en=0, req_ready=1; no stale response afterwards.
REQ-035 Prefetch (macro on): read 0x40, idle 3 cycles, read 0x41 -> response 1 cycle after accept, rsp_hit=1, data=ROM[0x41]; then read 0x50 -> rsp_hit=0, latency 2.
REQ-036 Wrap (macro on): read MEM_WORDS-1, idle, read 0 -> rsp_hit=1, data=ROM[0].
